axil_rr_arbiter: RTL and testbench
==================================

# axil_rr_arbiter

N-to-1 AXI4-Lite arbiter sharing one slave port between `N_MASTERS` masters, using the `crossbar` package struct types. Write and read paths are arbitrated independently with round-robin fairness. Each grant is held from address acceptance until the response handshake, so transactions never interleave. It is the per-slave arbitration stage of the parametrized crossbar.

## Interface
- `N_MASTERS`, 4: number of upstream masters, 2..16.
- `IDX_W`, `$clog2(N_MASTERS)`: grant index width, derived, not overridden.

- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `m_mosi` input `axi4lite_MOSI_t [N_MASTERS]`: master requests.
- `m_miso` output `axi4lite_MISO_t [N_MASTERS]`: per-master responses.
- `s_mosi` output `axi4lite_MOSI_t`: to shared slave.
- `s_miso` input `axi4lite_MISO_t`: from shared slave.

## Operation
- **Write FSM** states: `W_IDLE`, `W_XFER`, `W_RESP`.
  - `W_IDLE`: request vector is `m_mosi[i].awvalid`. If any bit is set, register the winner in `wgnt`, clear `aw_done` and `w_done`, and go to `W_XFER`.
  - `W_XFER`: forward the granted master's AW and W fields to `s_mosi` and return `awready`/`wready` to it. Set `aw_done` on the AW handshake and `w_done` on the W handshake. Each is gated off once done. The two may complete in either order or the same cycle. When both are done, go to `W_RESP`.
  - `W_RESP`: forward `bvalid`/`bresp` to the granted master and `bready` to the slave. On the B handshake: `wptr <= wgnt+1` (mod `N_MASTERS`), go to `W_IDLE`.
- **Read FSM** states: `R_IDLE`, `R_ADDR`, `R_DATA`.
  - Same pattern using `arvalid` requests and `rptr`/`rgnt`.
  - `R_ADDR` completes on the AR handshake; `R_DATA` completes on the R handshake (forwarding `rdata`, `rresp`).
- **Round-robin pick:** lowest requesting index `>= ptr`, wrapping to 0. Pointers move only on transaction completion.
- **Isolation:** non-granted masters, and all masters outside the active phase, see every ready/valid in `m_miso` at 0. Data fields are don't-care but driven 0.
- **Slave outputs:** `s_mosi` valids are 0 outside the active phase. `bready`/`rready` are 0 outside the response phase.
- **Concurrency:** read and write may be granted to the same or different masters at the same time; there is no cross-path ordering.
- **Wstrb/prot:** passed through unmodified.
- **W-before-AW:** a master asserting only `wvalid` is not a request. It waits until its `awvalid` wins arbitration.

## Timing
- **Reset:** both FSMs go to IDLE, `wptr`/`rptr`/`wgnt`/`rgnt` = 0, `aw_done`/`w_done` = 0. All `m_miso` outputs and all `s_mosi` valid/ready signals are 0 from the cycle after `rst` is sampled.
- **Arbitration latency:** 1 cycle. A request sampled in IDLE at edge k is visible on `s_mosi` in cycle k+1.
- **Forwarding:** combinational (valid/ready/data) between the granted master and the slave within a phase. No added latency per beat.
- **Minimum write:** 3 cycles (arb, AW+W, B) if the slave responds immediately. **Minimum read:** 3 cycles.
- **Back-to-back:** the next arbitration starts in the IDLE cycle after completion. There is one bubble cycle per transaction.
- **Mid-transaction `rst`:** abandons the transaction unconditionally. The slave must be reset alongside.
- A request withdrawn before grant is simply not selected. Withdrawal after grant violates AXI and is not handled.

## Structure
- **Add to package `crossbar`:** `wr_state_t` (`W_IDLE`, `W_XFER`, `W_RESP`) and `rd_state_t` (`R_IDLE`, `R_ADDR`, `R_DATA`) enums.
- **Sub-module `rr_pick`:** parameters `N`, `IDX_W`. Inputs `req[N]`, `ptr`. Outputs `gnt_idx`, `any`. Purely combinational; instantiated twice (write, read).
- FSMs, done flags and muxing live in `axil_rr_arbiter`. Target 200–300 lines total.

## Test plan
- **Reset:** with all `awvalid`/`arvalid` = 1, hold `rst` 3 cycles → all `m_miso` ready/valid = 0 and `s_mosi.awvalid = arvalid = 0` during reset; first grant goes to master 0.
- **Fairness:** masters 0–3 continuously request writes, slave always ready with immediate B → grant order 0,1,2,3,0,…; each write takes 3 cycles with 1 idle between.
- **AW/W skew:** granted master 2 presents W (`wdata=0xDEADBEEF`, `wstrb=0xFF`) 3 cycles before AW (`awaddr=0x1000`) → `s_mosi` carries each unchanged, `W_RESP` is entered only after both handshakes, `bresp` returns to master 2 only.
- **Concurrency:** master 1 reads 0x40 while master 3 writes 0x80; slave returns `rdata=0x1234` after 5 stall cycles → both complete independently; `rvalid` seen only by master 1, `bvalid` only by master 3.
- **Wrap/skip:** `rptr` = 3 with only master 1 requesting → master 1 granted; next `rptr` = 2.
- **Mid-read reset:** assert `rst` during `R_DATA` → the next cycle shows all outputs 0 and `R_IDLE`; the next read request from master 2 is granted normally.

Source files
------------

// File: rtl/crossbar.sv
// Shared AXI4-Lite channel bundles and arbiter state encodings used by the
// crossbar and its per-slave arbitration stage.
package crossbar;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;

    // Everything travelling from a master towards a slave.
    typedef struct packed {
        logic [ADDR_W-1:0] awaddr;
        logic [2:0]        awprot;
        logic              awvalid;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        logic              wvalid;
        logic              bready;
        logic [ADDR_W-1:0] araddr;
        logic [2:0]        arprot;
        logic              arvalid;
        logic              rready;
    } axi4lite_MOSI_t;

    // Everything travelling from a slave back towards a master.
    typedef struct packed {
        logic              awready;
        logic              wready;
        logic [1:0]        bresp;
        logic              bvalid;
        logic              arready;
        logic [DATA_W-1:0] rdata;
        logic [1:0]        rresp;
        logic              rvalid;
    } axi4lite_MISO_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_XFER = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: returns the lowest requesting index at or above ptr,
// wrapping past N-1 back to 0. Purely combinational.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    logic [IDX_W:0] cand;

    // Scan offsets from furthest to nearest so the nearest requester wins last.
    always_comb begin
        gnt_idx = '0;
        cand    = '0;
        any     = |req;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N)) begin
                cand = cand - (IDX_W+1)'(N);
            end
            if (req[cand[IDX_W-1:0]]) begin
                gnt_idx = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/axil_rr_arbiter.sv
// N-to-1 AXI4-Lite arbiter for one shared slave port. Write and read paths
// are arbitrated independently; a grant is held from address acceptance to
// the response handshake so transactions on a path never interleave.
module axil_rr_arbiter
    import crossbar::*;
#(
    parameter int N_MASTERS = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  axi4lite_MOSI_t m_mosi [N_MASTERS],
    output axi4lite_MISO_t m_miso [N_MASTERS],
    output axi4lite_MOSI_t s_mosi,
    input  axi4lite_MISO_t s_miso
);

    localparam int IDX_W = $clog2(N_MASTERS);

    wr_state_t        wr_state_reg, wr_state_next;
    rd_state_t        rd_state_reg, rd_state_next;
    logic [IDX_W-1:0] wgnt_reg, wgnt_next;
    logic [IDX_W-1:0] rgnt_reg, rgnt_next;
    logic [IDX_W-1:0] wptr_reg, wptr_next;
    logic [IDX_W-1:0] rptr_reg, rptr_next;
    logic             aw_done_reg, aw_done_next;
    logic             w_done_reg, w_done_next;

    logic [N_MASTERS-1:0] aw_req, ar_req;
    logic [IDX_W-1:0]     wpick, rpick;
    logic                 wany, rany;

    logic aw_phase, w_phase, b_phase, ar_phase, r_phase;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    // Pointer advance past the master that just finished, wrapping at N_MASTERS.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(N_MASTERS - 1)) ? '0 : idx + 1'b1;
    endfunction

    rr_pick #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_wr_pick (
        .req     (aw_req),
        .ptr     (wptr_reg),
        .gnt_idx (wpick),
        .any     (wany)
    );

    rr_pick #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_rd_pick (
        .req     (ar_req),
        .ptr     (rptr_reg),
        .gnt_idx (rpick),
        .any     (rany)
    );

    // Active phases; AW and W are each shut off as soon as their beat is taken.
    assign aw_phase = (wr_state_reg == W_XFER) && !aw_done_reg;
    assign w_phase  = (wr_state_reg == W_XFER) && !w_done_reg;
    assign b_phase  = (wr_state_reg == W_RESP);
    assign ar_phase = (rd_state_reg == R_ADDR);
    assign r_phase  = (rd_state_reg == R_DATA);

    assign aw_hs = aw_phase && m_mosi[wgnt_reg].awvalid && s_miso.awready;
    assign w_hs  = w_phase  && m_mosi[wgnt_reg].wvalid  && s_miso.wready;
    assign b_hs  = b_phase  && s_miso.bvalid && m_mosi[wgnt_reg].bready;
    assign ar_hs = ar_phase && m_mosi[rgnt_reg].arvalid && s_miso.arready;
    assign r_hs  = r_phase  && s_miso.rvalid && m_mosi[rgnt_reg].rready;

    // State, grant, pointer and done-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_reg <= W_IDLE;
            rd_state_reg <= R_IDLE;
            wgnt_reg     <= '0;
            rgnt_reg     <= '0;
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            aw_done_reg  <= 1'b0;
            w_done_reg   <= 1'b0;
        end else begin
            wr_state_reg <= wr_state_next;
            rd_state_reg <= rd_state_next;
            wgnt_reg     <= wgnt_next;
            rgnt_reg     <= rgnt_next;
            wptr_reg     <= wptr_next;
            rptr_reg     <= rptr_next;
            aw_done_reg  <= aw_done_next;
            w_done_reg   <= w_done_next;
        end
    end

    // Write path: arbitrate on awvalid, collect AW and W in any order, then B.
    always_comb begin
        wr_state_next = wr_state_reg;
        wgnt_next     = wgnt_reg;
        wptr_next     = wptr_reg;
        aw_done_next  = aw_done_reg;
        w_done_next   = w_done_reg;
        case (wr_state_reg)
            W_IDLE: begin
                if (wany) begin
                    wgnt_next     = wpick;
                    aw_done_next  = 1'b0;
                    w_done_next   = 1'b0;
                    wr_state_next = W_XFER;
                end
            end
            W_XFER: begin
                aw_done_next = aw_done_reg || aw_hs;
                w_done_next  = w_done_reg  || w_hs;
                if (aw_done_next && w_done_next) begin
                    wr_state_next = W_RESP;
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    wptr_next     = next_idx(wgnt_reg);
                    wr_state_next = W_IDLE;
                end
            end
            default: wr_state_next = W_IDLE;
        endcase
    end

    // Read path: arbitrate on arvalid, forward AR, then wait for the R beat.
    always_comb begin
        rd_state_next = rd_state_reg;
        rgnt_next     = rgnt_reg;
        rptr_next     = rptr_reg;
        case (rd_state_reg)
            R_IDLE: begin
                if (rany) begin
                    rgnt_next     = rpick;
                    rd_state_next = R_ADDR;
                end
            end
            R_ADDR: begin
                if (ar_hs) begin
                    rd_state_next = R_DATA;
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    rptr_next     = next_idx(rgnt_reg);
                    rd_state_next = R_IDLE;
                end
            end
            default: rd_state_next = R_IDLE;
        endcase
    end

    // Slave-facing mux: payload follows the grant, valids/readies only in phase.
    always_comb begin
        s_mosi         = '0;
        s_mosi.awaddr  = m_mosi[wgnt_reg].awaddr;
        s_mosi.awprot  = m_mosi[wgnt_reg].awprot;
        s_mosi.awvalid = aw_phase && m_mosi[wgnt_reg].awvalid;
        s_mosi.wdata   = m_mosi[wgnt_reg].wdata;
        s_mosi.wstrb   = m_mosi[wgnt_reg].wstrb;
        s_mosi.wvalid  = w_phase && m_mosi[wgnt_reg].wvalid;
        s_mosi.bready  = b_phase && m_mosi[wgnt_reg].bready;
        s_mosi.araddr  = m_mosi[rgnt_reg].araddr;
        s_mosi.arprot  = m_mosi[rgnt_reg].arprot;
        s_mosi.arvalid = ar_phase && m_mosi[rgnt_reg].arvalid;
        s_mosi.rready  = r_phase && m_mosi[rgnt_reg].rready;
    end

    genvar gi;
    for (gi = 0; gi < N_MASTERS; gi++) begin : g_master
        axi4lite_MISO_t miso;

        assign aw_req[gi] = m_mosi[gi].awvalid;
        assign ar_req[gi] = m_mosi[gi].arvalid;

        // Only the master holding a grant sees the slave, and only in phase.
        always_comb begin
            miso = '0;
            if (wgnt_reg == IDX_W'(gi)) begin
                miso.awready = aw_phase && s_miso.awready;
                miso.wready  = w_phase && s_miso.wready;
                miso.bvalid  = b_phase && s_miso.bvalid;
                miso.bresp   = b_phase ? s_miso.bresp : 2'b00;
            end
            if (rgnt_reg == IDX_W'(gi)) begin
                miso.arready = ar_phase && s_miso.arready;
                miso.rvalid  = r_phase && s_miso.rvalid;
                miso.rdata   = r_phase ? s_miso.rdata : '0;
                miso.rresp   = r_phase ? s_miso.rresp : 2'b00;
            end
        end

        assign m_miso[gi] = miso;
    end

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// Self-checking bench for axil_rr_arbiter: table-driven arbitration vectors,
// hand-written multi-cycle sequences, and a scoreboard of expected beats.
module tb_axil_rr_arbiter;
    import crossbar::*;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    axi4lite_MOSI_t m_mosi [N];
    axi4lite_MISO_t m_miso [N];
    axi4lite_MOSI_t s_mosi;
    axi4lite_MISO_t s_miso;

    always #5 clk = ~clk;

    axil_rr_arbiter #(.N_MASTERS(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .m_mosi (m_mosi),
        .m_miso (m_miso),
        .s_mosi (s_mosi),
        .s_miso (s_miso)
    );

    typedef struct {
        logic [3:0] mask;
        int         gnt;
    } vec_t;

    typedef struct {
        int          m;
        logic [63:0] data;
        logic [1:0]  resp;
    } resp_t;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] aw_q [$];
    logic [71:0] w_q  [$];
    logic [31:0] ar_q [$];
    resp_t       b_q  [$];
    resp_t       r_q  [$];

    vec_t wr_tab [10];
    vec_t rd_tab [3];

    function automatic logic [31:0] maddr(input int i);
        return 32'(i) * 32'h100;
    endfunction

    function automatic logic [63:0] mdata(input int i);
        return {32'hA5A5_0000, 32'(i)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got beat %h want no beat", name, act);
    endtask

    // Scoreboard: pop and compare whenever a handshake is visible.
    task automatic monitor();
        logic [31:0] ea;
        logic [71:0] ew;
        resp_t       er;
        if (rst) return;
        if (s_mosi.awvalid && s_miso.awready) begin
            if (aw_q.size() == 0) unexpected("sb_aw", 64'(s_mosi.awaddr));
            else begin
                ea = aw_q.pop_front();
                chk("sb_aw_addr", 64'(s_mosi.awaddr), 64'(ea));
            end
        end
        if (s_mosi.wvalid && s_miso.wready) begin
            if (w_q.size() == 0) unexpected("sb_w", s_mosi.wdata);
            else begin
                ew = w_q.pop_front();
                chk("sb_w_data", s_mosi.wdata, ew[71:8]);
                chk("sb_w_strb", 64'(s_mosi.wstrb), 64'(ew[7:0]));
            end
        end
        if (s_mosi.arvalid && s_miso.arready) begin
            if (ar_q.size() == 0) unexpected("sb_ar", 64'(s_mosi.araddr));
            else begin
                ea = ar_q.pop_front();
                chk("sb_ar_addr", 64'(s_mosi.araddr), 64'(ea));
            end
        end
        for (int i = 0; i < N; i++) begin
            if (m_miso[i].bvalid && m_mosi[i].bready) begin
                if (b_q.size() == 0) unexpected("sb_b", 64'(i));
                else begin
                    er = b_q.pop_front();
                    chk("sb_b_master", 64'(i), 64'(er.m));
                    chk("sb_b_resp", 64'(m_miso[i].bresp), 64'(er.resp));
                end
            end
            if (m_miso[i].rvalid && m_mosi[i].rready) begin
                if (r_q.size() == 0) unexpected("sb_r", 64'(i));
                else begin
                    er = r_q.pop_front();
                    chk("sb_r_master", 64'(i), 64'(er.m));
                    chk("sb_r_data", m_miso[i].rdata, er.data);
                    chk("sb_r_resp", 64'(m_miso[i].rresp), 64'(er.resp));
                end
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_quiet(input string name);
        for (int i = 0; i < N; i++) begin
            chk({name, "_awready"}, 64'(m_miso[i].awready), 64'd0);
            chk({name, "_wready"},  64'(m_miso[i].wready),  64'd0);
            chk({name, "_bvalid"},  64'(m_miso[i].bvalid),  64'd0);
            chk({name, "_arready"}, 64'(m_miso[i].arready), 64'd0);
            chk({name, "_rvalid"},  64'(m_miso[i].rvalid),  64'd0);
        end
        chk({name, "_s_awvalid"}, 64'(s_mosi.awvalid), 64'd0);
        chk({name, "_s_arvalid"}, 64'(s_mosi.arvalid), 64'd0);
    endtask

    task automatic push_resp(input int m, input logic [63:0] d, input logic [1:0] r, input bit is_read);
        resp_t e;
        e.m = m;
        e.data = d;
        e.resp = r;
        if (is_read) r_q.push_back(e);
        else b_q.push_back(e);
    endtask

    // One full write with an always-ready slave: arb, AW+W, B.
    task automatic do_write(input logic [3:0] mask, input int g);
        for (int i = 0; i < N; i++) begin
            m_mosi[i].awvalid = mask[i];
            m_mosi[i].wvalid  = mask[i];
        end
        aw_q.push_back(maddr(g));
        w_q.push_back({mdata(g), 8'h0F});
        push_resp(g, 64'd0, s_miso.bresp, 1'b0);
        sample();
        chk("wr_idle_awvalid", 64'(s_mosi.awvalid), 64'd0);
        adv();
        sample();
        for (int i = 0; i < N; i++)
            chk("wr_awready_grant", 64'(m_miso[i].awready), 64'(i == g));
        adv();
        sample();
        chk("wr_resp_bready", 64'(s_mosi.bready), 64'd1);
        for (int i = 0; i < N; i++)
            chk("wr_bvalid_grant", 64'(m_miso[i].bvalid), 64'(i == g));
        adv();
        $display("write mask=%b granted master %0d", mask, g);
    endtask

    // One full read with an always-ready slave: arb, AR, R.
    task automatic do_read(input logic [3:0] mask, input int g, input logic [63:0] d);
        for (int i = 0; i < N; i++) m_mosi[i].arvalid = mask[i];
        s_miso.rdata = d;
        ar_q.push_back(maddr(g) + 32'h8);
        push_resp(g, d, 2'b00, 1'b1);
        sample();
        chk("rd_idle_arvalid", 64'(s_mosi.arvalid), 64'd0);
        adv();
        sample();
        for (int i = 0; i < N; i++)
            chk("rd_arready_grant", 64'(m_miso[i].arready), 64'(i == g));
        adv();
        sample();
        chk("rd_data_rready", 64'(s_mosi.rready), 64'd1);
        for (int i = 0; i < N; i++)
            chk("rd_rvalid_grant", 64'(m_miso[i].rvalid), 64'(i == g));
        adv();
        $display("read  mask=%b granted master %0d", mask, g);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wr_tab[0] = '{4'b1111, 0};
        wr_tab[1] = '{4'b1111, 1};
        wr_tab[2] = '{4'b1111, 2};
        wr_tab[3] = '{4'b1111, 3};
        wr_tab[4] = '{4'b1111, 0};
        wr_tab[5] = '{4'b1010, 1};
        wr_tab[6] = '{4'b1001, 3};
        wr_tab[7] = '{4'b0110, 1};
        wr_tab[8] = '{4'b0010, 1};
        wr_tab[9] = '{4'b0001, 0};
        rd_tab[0] = '{4'b0100, 2};
        rd_tab[1] = '{4'b0010, 1};
        rd_tab[2] = '{4'b0101, 2};

        for (int i = 0; i < N; i++) begin
            m_mosi[i]         = '0;
            m_mosi[i].awaddr  = maddr(i);
            m_mosi[i].awprot  = 3'(i);
            m_mosi[i].wdata   = mdata(i);
            m_mosi[i].wstrb   = 8'h0F;
            m_mosi[i].bready  = 1'b1;
            m_mosi[i].araddr  = maddr(i) + 32'h8;
            m_mosi[i].arprot  = 3'(i);
            m_mosi[i].rready  = 1'b1;
            m_mosi[i].awvalid = 1'b1;
            m_mosi[i].arvalid = 1'b1;
        end
        s_miso         = '0;
        s_miso.awready = 1'b1;
        s_miso.wready  = 1'b1;
        s_miso.bvalid  = 1'b1;
        s_miso.arready = 1'b1;
        s_miso.rvalid  = 1'b1;
        rst = 1'b1;

        // Reset held with every master requesting: nothing may leak out.
        for (int c = 0; c < 3; c++) begin
            adv();
            sample();
            chk_all_quiet("reset");
            $display("reset cycle %0d checked", c);
        end
        adv();
        rst = 1'b0;
        for (int i = 0; i < N; i++) m_mosi[i].arvalid = 1'b0;

        // Fairness and wrap/skip on the write path.
        for (int k = 0; k < 10; k++) do_write(wr_tab[k].mask, wr_tab[k].gnt);
        for (int i = 0; i < N; i++) begin
            m_mosi[i].awvalid = 1'b0;
            m_mosi[i].wvalid  = 1'b0;
        end

        // W presented before AW by master 2; write pointer now at 1.
        s_miso.awready      = 1'b0;
        s_miso.bresp        = 2'b10;
        m_mosi[2].wdata     = 64'h0000_0000_DEAD_BEEF;
        m_mosi[2].wstrb     = 8'hFF;
        m_mosi[2].awaddr    = 32'h0000_1000;
        m_mosi[2].wvalid    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sample();
            chk("skew_w_only_wvalid", 64'(s_mosi.wvalid), 64'd0);
            chk("skew_w_only_wready", 64'(m_miso[2].wready), 64'd0);
            adv();
        end
        m_mosi[2].awvalid = 1'b1;
        aw_q.push_back(32'h0000_1000);
        w_q.push_back({64'h0000_0000_DEAD_BEEF, 8'hFF});
        push_resp(2, 64'd0, 2'b10, 1'b0);
        sample();
        adv();
        sample();
        chk("skew_wready_m2", 64'(m_miso[2].wready), 64'd1);
        chk("skew_awready_m2", 64'(m_miso[2].awready), 64'd0);
        adv();
        sample();
        chk("skew_w_gated", 64'(s_mosi.wvalid), 64'd0);
        chk("skew_no_bready", 64'(s_mosi.bready), 64'd0);
        chk("skew_state_xfer", 64'(dut.wr_state_reg), 64'(W_XFER));
        adv();
        s_miso.awready   = 1'b1;
        m_mosi[2].wvalid = 1'b0;
        sample();
        chk("skew_awready_m2_late", 64'(m_miso[2].awready), 64'd1);
        adv();
        m_mosi[2].awvalid = 1'b0;
        sample();
        chk("skew_state_resp", 64'(dut.wr_state_reg), 64'(W_RESP));
        for (int i = 0; i < N; i++)
            chk("skew_bvalid_only_m2", 64'(m_miso[i].bvalid), 64'(i == 2));
        adv();
        $display("skewed write by master 2 done");
        m_mosi[2].wdata  = mdata(2);
        m_mosi[2].wstrb  = 8'h0F;
        m_mosi[2].awaddr = maddr(2);
        s_miso.bresp     = 2'b00;

        // Concurrent read by master 1 and write by master 3, read stalls 5 cycles.
        s_miso.rvalid     = 1'b0;
        s_miso.rdata      = 64'h1234;
        m_mosi[1].araddr  = 32'h40;
        m_mosi[1].arvalid = 1'b1;
        m_mosi[3].awaddr  = 32'h80;
        m_mosi[3].awvalid = 1'b1;
        m_mosi[3].wvalid  = 1'b1;
        ar_q.push_back(32'h40);
        aw_q.push_back(32'h80);
        w_q.push_back({mdata(3), 8'h0F});
        push_resp(3, 64'd0, 2'b00, 1'b0);
        push_resp(1, 64'h1234, 2'b00, 1'b1);
        sample();
        adv();
        sample();
        chk("conc_arready_m1", 64'(m_miso[1].arready), 64'd1);
        chk("conc_arready_m3", 64'(m_miso[3].arready), 64'd0);
        chk("conc_awready_m3", 64'(m_miso[3].awready), 64'd1);
        adv();
        m_mosi[1].arvalid = 1'b0;
        m_mosi[3].awvalid = 1'b0;
        m_mosi[3].wvalid  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            sample();
            for (int i = 0; i < N; i++)
                chk("conc_stall_rvalid", 64'(m_miso[i].rvalid), 64'd0);
            chk("conc_stall_rready", 64'(s_mosi.rready), 64'd1);
            if (c == 0) begin
                chk("conc_bvalid_m1", 64'(m_miso[1].bvalid), 64'd0);
                chk("conc_bvalid_m3", 64'(m_miso[3].bvalid), 64'd1);
            end
            adv();
        end
        s_miso.rvalid = 1'b1;
        sample();
        for (int i = 0; i < N; i++)
            chk("conc_rvalid_only_m1", 64'(m_miso[i].rvalid), 64'(i == 1));
        chk("conc_rdata_m1", m_miso[1].rdata, 64'h1234);
        adv();
        $display("concurrent read m1 / write m3 done");
        m_mosi[1].araddr = maddr(1) + 32'h8;
        m_mosi[3].awaddr = maddr(3);

        // Read-path arbitration table; ends with read pointer at 3.
        for (int k = 0; k < 3; k++)
            do_read(rd_tab[k].mask, rd_tab[k].gnt, 64'h5000 + 64'(k));
        for (int i = 0; i < N; i++) m_mosi[i].arvalid = 1'b0;

        // Reset while master 2's read sits in R_DATA.
        s_miso.rvalid     = 1'b0;
        m_mosi[2].arvalid = 1'b1;
        ar_q.push_back(maddr(2) + 32'h8);
        push_resp(2, 64'h9999, 2'b00, 1'b1);
        sample();
        adv();
        sample();
        adv();
        m_mosi[2].arvalid = 1'b0;
        sample();
        chk("midrst_in_rdata", 64'(dut.rd_state_reg), 64'(R_DATA));
        adv();
        rst = 1'b1;
        m_mosi[2].arvalid = 1'b1;
        sample();
        adv();
        rst = 1'b0;
        r_q.delete();
        ar_q.push_back(maddr(2) + 32'h8);
        push_resp(2, 64'h7777, 2'b00, 1'b1);
        s_miso.rdata  = 64'h7777;
        s_miso.rvalid = 1'b1;
        sample();
        chk_all_quiet("midrst");
        chk("midrst_rready", 64'(s_mosi.rready), 64'd0);
        chk("midrst_state_idle", 64'(dut.rd_state_reg), 64'(R_IDLE));
        adv();
        sample();
        for (int i = 0; i < N; i++)
            chk("midrst_regrant_m2", 64'(m_miso[i].arready), 64'(i == 2));
        adv();
        m_mosi[2].arvalid = 1'b0;
        sample();
        chk("midrst_rvalid_m2", 64'(m_miso[2].rvalid), 64'd1);
        adv();
        $display("mid-read reset and re-grant to master 2 done");

        for (int c = 0; c < 3; c++) begin
            sample();
            adv();
        end
        chk("sb_drain_aw", 64'(aw_q.size()), 64'd0);
        chk("sb_drain_w",  64'(w_q.size()),  64'd0);
        chk("sb_drain_b",  64'(b_q.size()),  64'd0);
        chk("sb_drain_ar", 64'(ar_q.size()), 64'd0);
        chk("sb_drain_r",  64'(r_q.size()),  64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
